// File: rtl/fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_out
// Purpose  : Prefetching read-side adapter; turns a FIFO empty/rd_en port into
//            a registered valid/ready stream through a 3-entry output buffer.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_stream_out #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  flush_i,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    input  logic                  m_ready_i,
    output logic [1:0]            level_o
);

    localparam logic [2:0] c_depth    = 3'd3;
    localparam logic [1:0] c_last_idx = 2'd2;

    generate
        if (DATA_WIDTH < 1) begin : g_width_check
            $error("fifo_stream_out: DATA_WIDTH must be >= 1");
        end
    endgenerate

    logic [1:0]            r_count;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_buf [0:2];

    logic [2:0] w_occupancy;
    logic       w_capture;
    logic       w_pop;

    function automatic logic [1:0] next_ptr(input logic [1:0] ptr);
        return (ptr == c_last_idx) ? 2'd0 : ptr + 2'd1;
    endfunction

    // Words held plus the one still returning from the FIFO must fit in the buffer.
    assign w_occupancy  = {1'b0, r_count} + {2'b00, r_inflight};
    assign fifo_rd_en_o = rst_n && !fifo_empty_i && !flush_i && (w_occupancy < c_depth);
    assign w_capture    = r_inflight && !flush_i;
    assign w_pop        = m_valid_o && m_ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_inflight <= 1'b0;
        end else if (flush_i) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= fifo_rd_en_o;
            if (w_capture) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_capture, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < 3; i++) begin : g_entry
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_buf[i] <= '0;
                end else if (w_capture && (r_wr_ptr == 2'(i))) begin
                    r_buf[i] <= fifo_rd_data_i;
                end
            end
        end
    endgenerate

    always_comb begin
        m_data_o = r_buf[0];
        case (r_rd_ptr)
            2'd1:    m_data_o = r_buf[1];
            2'd2:    m_data_o = r_buf[2];
            default: m_data_o = r_buf[0];
        endcase
    end

    assign m_valid_o = (r_count != 2'd0);
    assign level_o   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_stream_out
// Purpose  : Directed and table-driven checks of fifo_stream_out against a
//            behavioural synchronous FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_stream_out;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] f_rdata;
    logic       flush = 1'b0;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready = 1'b0;
    logic [1:0] level;

    logic       hold = 1'b0;
    logic       f_wr = 1'b0;
    logic [7:0] f_wdata = 8'h00;
    logic [7:0] f_mem [0:63];
    logic [5:0] f_wp;
    logic [5:0] f_rp;
    logic [6:0] f_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fifo_stream_out #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty_i   (fifo_empty),
        .fifo_rd_en_o   (fifo_rd_en),
        .fifo_rd_data_i (f_rdata),
        .flush_i        (flush),
        .m_valid_o      (m_valid),
        .m_data_o       (m_data),
        .m_ready_i      (m_ready),
        .level_o        (level)
    );

    // Synchronous FIFO model: read data appears the cycle after rd_en.
    assign fifo_empty = hold || (f_cnt == 7'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_wp    <= '0;
            f_rp    <= '0;
            f_cnt   <= '0;
            f_rdata <= '0;
        end else begin
            if (f_wr) begin
                f_mem[f_wp] <= f_wdata;
                f_wp        <= f_wp + 6'd1;
            end
            if (fifo_rd_en) begin
                f_rdata <= f_mem[f_rp];
                f_rp    <= f_rp + 6'd1;
            end
            f_cnt <= f_cnt + 7'(f_wr) - 7'(fifo_rd_en);
        end
    end

    typedef struct {
        logic       rdy;
        logic       rd;
        logic       v;
        logic [7:0] d;
        logic [1:0] lvl;
    } vec_t;

    vec_t tbl [0:13];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic preload(input logic [7:0] first, input int n);
        hold = 1'b1;
        for (int i = 0; i < n; i++) begin
            f_wr    = 1'b1;
            f_wdata = first + 8'(i);
            tick();
        end
        f_wr = 1'b0;
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            check("idle_rd_en", fifo_rd_en, 0);
            check("idle_valid", m_valid, 0);
            check("idle_level", level, 0);
            tick();
        end
    endtask

    task automatic expect_stream(input logic [7:0] first, input int n);
        int got = 0;
        int waited = 0;
        m_ready = 1'b1;
        while (got < n && waited < 200) begin
            if (m_valid) begin
                check("stream_data", m_data, first + 8'(got));
                got++;
            end
            tick();
            waited++;
        end
        check("stream_count", got, n);
    endtask

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 8'hA0, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hA0, 2'd2};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'hA0, 2'd3};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'hA0, 2'd3};
        tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'hA1, 2'd2};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'hA2, 2'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'hA3, 2'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 8'hA4, 2'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 8'hA5, 2'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 8'hA6, 2'd1};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 8'hA7, 2'd1};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h00, 2'd0};

        // Reset with an empty FIFO
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        idle_check(20);

        // Full-throughput burst
        m_ready = 1'b1;
        preload(8'h01, 16);
        hold = 1'b0;
        #1;
        check("burst_rd_en_k0", fifo_rd_en, 1);
        for (int k = 0; k < 19; k++) begin
            if (k >= 2 && k <= 17) begin
                check("burst_valid", m_valid, 1);
                check("burst_data", m_data, 8'(k - 1));
            end else begin
                check("burst_valid_off", m_valid, 0);
            end
            tick();
        end

        // Backpressure, cycle-by-cycle table
        m_ready = 1'b0;
        preload(8'hA0, 8);
        hold = 1'b0;
        #1;
        for (int i = 0; i < 14; i++) begin
            m_ready = tbl[i].rdy;
            check("bp_rd_en", fifo_rd_en, tbl[i].rd);
            check("bp_valid", m_valid, tbl[i].v);
            check("bp_level", level, tbl[i].lvl);
            if (tbl[i].v) begin
                check("bp_data", m_data, tbl[i].d);
            end
            tick();
        end

        // Flush with two words held and one in flight
        m_ready = 1'b0;
        preload(8'hB0, 8);
        hold = 1'b0;
        #1;
        repeat (3) tick();
        check("pre_flush_level", level, 2);
        flush = 1'b1;
        #1;
        check("flush_rd_en", fifo_rd_en, 0);
        tick();
        flush   = 1'b0;
        m_ready = 1'b1;
        check("post_flush_valid", m_valid, 0);
        check("post_flush_level", level, 0);
        flush = 1'b1;
        #1;
        check("flush_blocks_rd", fifo_rd_en, 0);
        flush = 1'b0;
        #1;
        check("unflushed_rd", fifo_rd_en, 1);
        expect_stream(8'hB3, 5);

        // Random traffic with scoreboard
        begin
            logic [7:0] q[$];
            logic [7:0] wval = 8'h00;
            int sent = 0;
            int received = 0;
            int cycles = 0;
            while (received < 1000 && cycles < 20000) begin
                m_ready = 1'($urandom_range(0, 1));
                if (sent < 1000 && f_cnt < 7'd60 && $urandom_range(0, 1) == 1) begin
                    f_wr    = 1'b1;
                    f_wdata = wval;
                    q.push_back(wval);
                    wval++;
                    sent++;
                end else begin
                    f_wr = 1'b0;
                end
                #1;
                check("rd_while_empty", fifo_rd_en & fifo_empty, 0);
                if (m_valid && m_ready) begin
                    if (q.size() == 0) begin
                        check("extra_word", m_data, 9'h100);
                    end else begin
                        check("rand_order", m_data, q.pop_front());
                    end
                    received++;
                end
                tick();
                cycles++;
            end
            f_wr = 1'b0;
            check("rand_received", received, 1000);
        end

        // Asynchronous reset in the middle of a burst
        m_ready = 1'b1;
        repeat (4) tick();
        preload(8'hC0, 16);
        hold = 1'b0;
        repeat (4) tick();
        check("pre_rst_valid", m_valid, 1);
        check("pre_rst_rd_en", fifo_rd_en, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_valid", m_valid, 0);
        check("async_rd_en", fifo_rd_en, 0);
        check("async_level", level, 0);
        check("async_data", m_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        idle_check(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
